line_clear_ctrl: RTL and testbench

//  Owns the playfield grid consumed by color_mapper and the score it renders.

---
 rtl/line_clear_ctrl.sv | 169 ++++++++++++++++
 tb/tb_line_clear_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_ctrl.sv
// Purpose : owns the playfield grid and score; writes 4-cell piece locks, then
//           scans rows bottom-to-top, collapses every full row and scores the lock.
// Latency : lock_ready returns 23+n cycles after the transfer edge (n = rows cleared);
//           written cells are visible on grid the cycle after the transfer.
// Backpressure: lock_ready is high only in IDLE; a held lock_valid waits, while busy it
//           is ignored. clear_grid overrides everything, including a same-edge lock.
// Ports   : Clk, Reset (async, active-high), clear_grid, lock_valid/lock_ready,
//           lock_x[4], lock_y[4], lock_color -> grid[x][y], score, busy, done, lines.
module line_clear_ctrl #(
    parameter int COLS      = 10,
    parameter int ROWS      = 22,
    parameter int SCORE_MAX = 999
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       clear_grid,
    input  logic       lock_valid,
    output logic       lock_ready,
    input  logic [3:0] lock_x [4],
    input  logic [4:0] lock_y [4],
    input  logic [2:0] lock_color,
    output logic [2:0] grid [COLS][ROWS],
    output logic [9:0] score,
    output logic       busy,
    output logic       done,
    output logic [2:0] lines
);

    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   r_q, r_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0]      grid_q [COLS][ROWS];
    logic [2:0]      grid_d [COLS][ROWS];
    logic [9:0]      score_q, score_d;
    logic [2:0]      lines_q, lines_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            row_full;
    logic            above_full;
    logic [RW-1:0]   r_above;
    logic [10:0]     score_sum;

    // Fullness of the current row and of the row directly above it. The row
    // above is what SHIFT moves into row r, so SHIFT can re-check the shifted
    // row itself instead of spending an extra SCAN cycle on it.
    always_comb begin
        row_full   = 1'b1;
        above_full = (r_q != '0);
        r_above    = (r_q == '0) ? '0 : r_q - RW'(1);
        for (int x = 0; x < COLS; x++) begin
            if (grid_q[x][r_q] == 3'd0) row_full = 1'b0;
            if (grid_q[x][r_above] == 3'd0) above_full = 1'b0;
        end
    end

    // Score add is done at 11 bits so the saturation compare sees the carry.
    assign score_sum = 11'(score_q) + 11'(cnt_q) * 11'(cnt_q);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        grid_d  = grid_q;
        score_d = score_q;
        lines_d = lines_q;

        case (state_q)
            IDLE: begin
                if (lock_valid) begin
                    // Out-of-range cells are dropped; duplicates just rewrite the same value.
                    for (int i = 0; i < 4; i++) begin
                        if (32'(lock_x[i]) < COLS && 32'(lock_y[i]) < ROWS)
                            grid_d[lock_x[i]][lock_y[i]] = lock_color;
                    end
                    r_d     = RW'(ROWS - 1);
                    cnt_d   = 3'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_d = SHIFT;
                end else if (r_q == '0) begin
                    lines_d = cnt_q;
                    state_d = DONE;
                end else begin
                    r_d = r_q - RW'(1);
                end
            end
            SHIFT: begin
                for (int x = 0; x < COLS; x++) begin
                    for (int y = 1; y < ROWS; y++) begin
                        if (y <= int'(r_q)) grid_d[x][y] = grid_q[x][y-1];
                    end
                    grid_d[x][0] = 3'd0;
                end
                cnt_d = cnt_q + 3'd1;
                // Row r now holds the old row above; keep shifting while that is full.
                if (above_full) begin
                    state_d = SHIFT;
                end else if (r_q == '0) begin
                    lines_d = cnt_q + 3'd1;
                    state_d = DONE;
                end else begin
                    r_d     = r_q - RW'(1);
                    state_d = SCAN;
                end
            end
            DONE: begin
                score_d = (score_sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear_grid) begin
            for (int x = 0; x < COLS; x++)
                for (int y = 0; y < ROWS; y++)
                    grid_d[x][y] = 3'd0;
            score_d = 10'd0;
            lines_d = 3'd0;
            state_d = IDLE;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= 3'd0;
            score_q <= 10'd0;
            lines_q <= 3'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int x = 0; x < COLS; x++)
                for (int y = 0; y < ROWS; y++)
                    grid_q[x][y] <= 3'd0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            lines_q <= lines_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            grid_q  <= grid_d;
        end
    end

    assign grid       = grid_q;
    assign score      = score_q;
    assign lines      = lines_q;
    assign lock_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Purpose : directed self-checking bench for line_clear_ctrl (locks, clears, scoring).
// Latency : done expected on the (23+n)th cycle after a transfer, ready one cycle later.
// Backpressure: each lock waits for lock_ready before driving lock_valid.
module tb_line_clear_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       clear_grid;
    logic       lock_valid;
    logic       lock_ready;
    logic [3:0] lock_x [4];
    logic [4:0] lock_y [4];
    logic [2:0] lock_color;
    logic [2:0] grid [10][22];
    logic [9:0] score;
    logic       busy;
    logic       done;
    logic [2:0] lines;

    int checks   = 0;
    int failures = 0;

    line_clear_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear_grid (clear_grid),
        .lock_valid (lock_valid),
        .lock_ready (lock_ready),
        .lock_x     (lock_x),
        .lock_y     (lock_y),
        .lock_color (lock_color),
        .grid       (grid),
        .score      (score),
        .busy       (busy),
        .done       (done),
        .lines      (lines)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int nz();
        int n = 0;
        for (int x = 0; x < 10; x++)
            for (int y = 0; y < 22; y++)
                if (grid[x][y] != 3'd0) n++;
        return n;
    endfunction

    // Drives one lock, then reports done latency (in cycles after the transfer
    // edge), lines while done, the first written cell and busy one cycle after
    // the transfer, and lock_ready one cycle after done.
    task automatic do_lock(input logic [15:0] xs, input logic [19:0] ys, input logic [2:0] col,
                           output int cyc, output logic [2:0] ln, output logic [2:0] first_cell,
                           output logic busy1, output logic rdy_after);
        int guard = 0;
        @(negedge Clk);
        while (!lock_ready && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        if (!lock_ready) chk("lock_ready_wait", 32'(lock_ready), 1);
        for (int i = 0; i < 4; i++) begin
            lock_x[i] = xs[4*i +: 4];
            lock_y[i] = ys[5*i +: 5];
        end
        lock_color = col;
        lock_valid = 1'b1;
        @(posedge Clk);
        #1 lock_valid = 1'b0;
        cyc = 0; ln = 3'd0; first_cell = 3'd0; busy1 = 1'b0; rdy_after = 1'b0;
        while (cyc < 60) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) begin
                busy1 = busy;
                if (xs[3:0] < 4'd10 && ys[4:0] < 5'd22) first_cell = grid[xs[3:0]][ys[4:0]];
            end
            if (done) begin
                ln = lines;
                break;
            end
        end
        @(negedge Clk);
        rdy_after = lock_ready;
    endtask

    task automatic do_clear();
        @(negedge Clk);
        clear_grid = 1'b1;
        @(posedge Clk);
        #1 clear_grid = 1'b0;
    endtask

    // Fills columns 0..ncols-1 of rows y_lo..y_hi, four cells per lock.
    task automatic fill_rows(input int y_lo, input int y_hi, input int ncols);
        int total, c, cyc;
        logic [15:0] xs;
        logic [19:0] ys;
        logic [2:0] ln, fc;
        logic b1, ra;
        total = (y_hi - y_lo + 1) * ncols;
        for (int base = 0; base < total; base += 4) begin
            for (int j = 0; j < 4; j++) begin
                c = (base + j < total) ? base + j : total - 1;
                xs[4*j +: 4] = 4'(c % ncols);
                ys[5*j +: 5] = 5'(y_lo + c / ncols);
            end
            do_lock(xs, ys, 3'(((base / 4) % 7) + 1), cyc, ln, fc, b1, ra);
        end
    endtask

    task automatic tetris(output int cyc, output logic [2:0] ln);
        logic [2:0] fc;
        logic b1, ra;
        fill_rows(18, 21, 9);
        do_lock({4'd9, 4'd9, 4'd9, 4'd9}, {5'd21, 5'd20, 5'd19, 5'd18}, 3'd7, cyc, ln, fc, b1, ra);
    endtask

    task automatic single(output int cyc, output logic [2:0] ln);
        logic [2:0] fc;
        logic b1, ra;
        fill_rows(21, 21, 9);
        do_lock({4'd9, 4'd9, 4'd9, 4'd9}, {5'd21, 5'd21, 5'd21, 5'd21}, 3'd4, cyc, ln, fc, b1, ra);
    endtask

    initial begin
        int cyc, dones;
        logic [2:0] ln, fc;
        logic b1, ra;

        Reset = 1'b1; clear_grid = 1'b0; lock_valid = 1'b0; lock_color = 3'd0;
        for (int i = 0; i < 4; i++) begin
            lock_x[i] = 4'd0;
            lock_y[i] = 5'd0;
        end
        repeat (3) @(negedge Clk);
        chk("rst_ready", 32'(lock_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_lines", 32'(lines), 0);
        chk("rst_grid_nz", nz(), 0);
        Reset = 1'b0;

        // Plain lock on an empty grid: no row completes.
        do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {5'd21, 5'd21, 5'd21, 5'd21}, 3'd2, cyc, ln, fc, b1, ra);
        chk("t2_cell_next_cycle", 32'(fc), 2);
        chk("t2_busy", 32'(b1), 1);
        chk("t2_done_cycle", cyc, 23);
        chk("t2_lines", 32'(ln), 0);
        chk("t2_ready_after", 32'(ra), 1);
        chk("t2_score", 32'(score), 0);
        chk("t2_cell3", 32'(grid[3][21]), 2);
        chk("t2_nz", nz(), 4);

        // Single clear with an occupied row above it.
        do_clear();
        chk("clr_nz", nz(), 0);
        do_lock({4'd7, 4'd6, 4'd5, 4'd4}, {5'd21, 5'd21, 5'd21, 5'd21}, 3'd1, cyc, ln, fc, b1, ra);
        do_lock({4'd9, 4'd9, 4'd9, 4'd8}, {5'd21, 5'd21, 5'd21, 5'd21}, 3'd1, cyc, ln, fc, b1, ra);
        do_lock({4'd0, 4'd0, 4'd0, 4'd0}, {5'd20, 5'd20, 5'd20, 5'd20}, 3'd3, cyc, ln, fc, b1, ra);
        chk("t3_pre_lines", 32'(ln), 0);
        do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {5'd21, 5'd21, 5'd21, 5'd21}, 3'd5, cyc, ln, fc, b1, ra);
        chk("t3_done_cycle", cyc, 24);
        chk("t3_lines", 32'(ln), 1);
        chk("t3_score", 32'(score), 1);
        chk("t3_row21_x0", 32'(grid[0][21]), 3);
        chk("t3_row21_x4", 32'(grid[4][21]), 0);
        chk("t3_row20_x0", 32'(grid[0][20]), 0);
        chk("t3_nz", nz(), 1);
        chk("t3_lines_held", 32'(lines), 1);

        // Tetris.
        do_clear();
        chk("t4_score_cleared", 32'(score), 0);
        tetris(cyc, ln);
        chk("t4_done_cycle", cyc, 27);
        chk("t4_lines", 32'(ln), 4);
        chk("t4_score", 32'(score), 16);
        chk("t4_nz", nz(), 0);

        // Rows 21 and 19 complete, row 20 partial.
        fill_rows(21, 21, 9);
        fill_rows(20, 20, 4);
        fill_rows(19, 19, 9);
        do_lock({4'd9, 4'd9, 4'd9, 4'd9}, {5'd19, 5'd19, 5'd19, 5'd21}, 3'd6, cyc, ln, fc, b1, ra);
        chk("t5_done_cycle", cyc, 25);
        chk("t5_lines", 32'(ln), 2);
        chk("t5_score", 32'(score), 20);
        chk("t5_row21_x3", 32'(grid[3][21]), 1);
        chk("t5_row21_x4", 32'(grid[4][21]), 0);
        chk("t5_row20_x0", 32'(grid[0][20]), 0);
        chk("t5_nz", nz(), 4);

        // One cell off the right edge is dropped.
        do_clear();
        do_lock({4'd3, 4'd2, 4'd1, 4'd12}, {5'd21, 5'd21, 5'd21, 5'd21}, 3'd5, cyc, ln, fc, b1, ra);
        chk("t6_x12_done_cycle", cyc, 23);
        chk("t6_x12_nz", nz(), 3);
        chk("t6_x12_cell1", 32'(grid[1][21]), 5);

        // clear_grid on the transfer edge discards the lock.
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            lock_x[i] = 4'(i);
            lock_y[i] = 5'd20;
        end
        lock_color = 3'd6;
        lock_valid = 1'b1;
        clear_grid = 1'b1;
        @(posedge Clk);
        #1 lock_valid = 1'b0;
        clear_grid = 1'b0;
        chk("t6_clr_xfer_nz", nz(), 0);
        chk("t6_clr_xfer_ready", 32'(lock_ready), 1);
        chk("t6_clr_xfer_busy", 32'(busy), 0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (done) dones++;
        end
        chk("t6_clr_xfer_no_done", dones, 0);

        // Saturation: 62 tetrises + 3 singles = 995, then one more tetris.
        for (int i = 0; i < 62; i++) tetris(cyc, ln);
        chk("t6_score_992", 32'(score), 992);
        for (int i = 0; i < 3; i++) single(cyc, ln);
        chk("t6_score_995", 32'(score), 995);
        tetris(cyc, ln);
        chk("t6_sat_lines", 32'(ln), 4);
        chk("t6_sat_score", 32'(score), 999);
        single(cyc, ln);
        chk("t6_sat_hold", 32'(score), 999);

        // Asynchronous reset in the middle of a scan.
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            lock_x[i] = 4'(i);
            lock_y[i] = 5'd21;
        end
        lock_color = 3'd2;
        lock_valid = 1'b1;
        @(posedge Clk);
        #1 lock_valid = 1'b0;
        repeat (5) @(negedge Clk);
        chk("t1_mid_busy", 32'(busy), 1);
        chk("t1_mid_nz", nz(), 4);
        Reset = 1'b1;
        #1;
        chk("t1_rst_ready", 32'(lock_ready), 1);
        chk("t1_rst_busy", 32'(busy), 0);
        chk("t1_rst_score", 32'(score), 0);
        chk("t1_rst_nz", nz(), 0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (30) @(negedge Clk);
        chk("t1_rst_score_after", 32'(score), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
